nascom_vram_arb: RTL and testbench

Arbitrates the shared 1K video RAM between the video refresh fetch and Z80 CPU accesses on the NASCOM board model. Video has priority; the CPU is held off with Z80 WAIT until its slot is granted. It drives the RAM chip controls and the load strobe of the character shift-register latch. It is built from the same synchronous-state, async-clear flip-flop style as the TTL parts it sequences.

---
 rtl/nascom_vram_arb.sv | 140 ++++++++++++++
 tb/tb_nascom_vram_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nascom_vram_arb.sv
// NASCOM video RAM arbiter: video fetch has priority,
// the Z80 is held off with WAIT until its slot is granted.
module nascom_vram_arb #(
  parameter int VID_CYCLES = 2,
  parameter int CPU_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vid_req,
  input  logic [9:0] vid_addr,
  input  logic       cpu_vsel_n,
  input  logic       cpu_wr_n,
  input  logic [9:0] cpu_addr,
  output logic [9:0] ram_addr,
  output logic       ram_cs_n,
  output logic       ram_we_n,
  output logic       vid_latch,
  output logic       cpu_grant,
  output logic       wait_n,
  output logic       vid_overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VFETCH = 2'd1,
    CACC   = 2'd2
  } state_t;

  localparam logic [2:0] VLAST = 3'(VID_CYCLES - 1);
  localparam logic [2:0] CLAST = 3'(CPU_CYCLES - 1);

  state_t     state, nxt_state;
  logic [2:0] cnt, nxt_cnt;
  logic       vid_pend;
  logic       cpu_done;
  logic       enter_vf;
  logic       vid_last;
  logic       cpu_last;
  logic       vid_any;

  assign vid_last = (state == VFETCH) && (cnt == VLAST);
  assign cpu_last = (state == CACC) && (cnt == CLAST);
  assign vid_any  = vid_pend | vid_req;

  // state and cycle counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // next-state: video wins, a CPU slot runs to completion
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    enter_vf  = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        nxt_cnt = 3'd0;
        if (vid_any) begin
          nxt_state = VFETCH;
          enter_vf  = 1'b1;
        end else if (!cpu_vsel_n && !cpu_done) begin
          nxt_state = CACC;
        end
      end
      state == VFETCH: begin
        if (vid_last) begin
          nxt_state = IDLE;
          nxt_cnt   = 3'd0;
        end else begin
          nxt_cnt = cnt + 3'd1;
        end
      end
      state == CACC: begin
        if (cpu_last) begin
          nxt_cnt = 3'd0;
          if (vid_any) begin
            nxt_state = VFETCH;
            enter_vf  = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end else begin
          nxt_cnt = cnt + 3'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 3'd0;
      end
    endcase
  end

  // pending video request, overrun pulse and CPU-done flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_pend    <= 1'b0;
      vid_overrun <= 1'b0;
      cpu_done    <= 1'b0;
    end else begin
      vid_overrun <= vid_req & vid_pend & ~enter_vf;
      if (enter_vf)
        vid_pend <= 1'b0;
      else if (vid_req)
        vid_pend <= 1'b1;
      if (cpu_vsel_n)
        cpu_done <= 1'b0;
      else if (cpu_last)
        cpu_done <= 1'b1;
    end
  end

  // RAM controls decoded from registered state
  always_comb begin
    ram_addr  = 10'd0;
    ram_cs_n  = 1'b1;
    ram_we_n  = 1'b1;
    vid_latch = 1'b0;
    cpu_grant = 1'b0;
    if (state == VFETCH) begin
      ram_addr  = vid_addr;
      ram_cs_n  = 1'b0;
      vid_latch = vid_last;
    end else if (state == CACC) begin
      ram_addr  = cpu_addr;
      ram_cs_n  = 1'b0;
      cpu_grant = 1'b1;
      ram_we_n  = (cnt == 3'd0) ? 1'b1 : cpu_wr_n;
    end
  end

  assign wait_n = ~reset_n |
                  ~(~cpu_vsel_n & ~cpu_done & ~cpu_last);

endmodule

// File: tb/tb_nascom_vram_arb.sv
// Directed bench for nascom_vram_arb with a per-cycle
// expected-output scoreboard on two parameterisations.
module tb_nascom_vram_arb;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vid_req = 1'b0;
  logic [9:0] vid_addr = 10'h155;
  logic       cpu_vsel_n = 1'b1;
  logic       cpu_wr_n = 1'b1;
  logic [9:0] cpu_addr = 10'h3FF;

  logic [9:0] a0, a1;
  logic cs0, we0, lt0, gr0, wt0, ov0;
  logic cs1, we1, lt1, gr1, wt1, ov1;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  bit          sel_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  nascom_vram_arb u0 (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_vsel_n(cpu_vsel_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr),
    .ram_addr(a0), .ram_cs_n(cs0), .ram_we_n(we0),
    .vid_latch(lt0), .cpu_grant(gr0),
    .wait_n(wt0), .vid_overrun(ov0)
  );

  nascom_vram_arb #(.VID_CYCLES(2), .CPU_CYCLES(4)) u1 (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_vsel_n(cpu_vsel_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr),
    .ram_addr(a1), .ram_cs_n(cs1), .ram_we_n(we1),
    .vid_latch(lt1), .cpu_grant(gr1),
    .wait_n(wt1), .vid_overrun(ov1)
  );

  wire [15:0] obs0 = {a0, cs0, we0, lt0, gr0, wt0, ov0};
  wire [15:0] obs1 = {a1, cs1, we1, lt1, gr1, wt1, ov1};

  // addr, cs_n, we_n, latch, grant, wait_n, overrun
  function automatic logic [15:0] v(
    input logic [9:0] a, input logic cs, input logic we,
    input logic lt, input logic gr, input logic wt,
    input logic ov);
    return {a, cs, we, lt, gr, wt, ov};
  endfunction

  // one clock cycle: drive after the edge, check at negedge
  task automatic cyc(
    input bit rst, input bit req, input bit vsel,
    input bit wr, input bit sel,
    input logic [15:0] e, input string tag);
    logic [15:0] exp_v, obs;
    bit          s;
    string       t;
    @(posedge clk);
    #1;
    reset_n    = rst;
    vid_req    = req;
    cpu_vsel_n = vsel;
    cpu_wr_n   = wr;
    exp_q.push_back(e);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    s     = sel_q.pop_front();
    t     = tag_q.pop_front();
    obs   = s ? obs1 : obs0;
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             t, obs, exp_v);
    end
  endtask

  logic [15:0] idl, idlw;

  initial begin
    idl  = v(10'h000, 1, 1, 0, 0, 1, 0);
    idlw = v(10'h000, 1, 1, 0, 0, 0, 0);

    // reset state, wait_n forced high in reset
    cyc(0, 0, 1, 1, 0, idl, "rst_idle");
    cyc(0, 0, 0, 1, 0, idl, "rst_wait");
    cyc(1, 0, 1, 1, 0, idl, "post_rst");

    // reset in the middle of a fetch
    cyc(1, 1, 1, 1, 0, idl, "rf_req");
    cyc(1, 0, 1, 1, 0, v(10'h155, 0, 1, 0, 0, 1, 0), "rf_vf0");
    cyc(0, 0, 1, 1, 0, idl, "rf_abort");
    cyc(1, 0, 1, 1, 0, idl, "rf_idle1");
    cyc(1, 0, 1, 1, 0, idl, "rf_idle2");

    // lone video fetch
    cyc(1, 1, 1, 1, 0, idl, "lv_req");
    cyc(1, 0, 1, 1, 0, v(10'h155, 0, 1, 0, 0, 1, 0), "lv_vf0");
    cyc(1, 0, 1, 1, 0, v(10'h155, 0, 1, 1, 0, 1, 0), "lv_vf1");
    cyc(1, 0, 1, 1, 0, idl, "lv_done");

    // lone CPU write
    cyc(1, 0, 0, 0, 0, idlw, "cw_req");
    cyc(1, 0, 0, 0, 0, v(10'h3FF, 0, 1, 0, 1, 0, 0), "cw_c0");
    cyc(1, 0, 0, 0, 0, v(10'h3FF, 0, 0, 0, 1, 1, 0), "cw_c1");
    cyc(1, 0, 0, 0, 0, idl, "cw_nogrant1");
    cyc(1, 0, 0, 0, 0, idl, "cw_nogrant2");
    cyc(1, 0, 1, 1, 0, idl, "cw_release");

    // simultaneous video and CPU read
    cyc(1, 1, 0, 1, 0, idlw, "sim_req");
    cyc(1, 0, 0, 1, 0, v(10'h155, 0, 1, 0, 0, 0, 0), "sim_vf0");
    cyc(1, 0, 0, 1, 0, v(10'h155, 0, 1, 1, 0, 0, 0), "sim_vf1");
    cyc(1, 0, 0, 1, 0, idlw, "sim_gap");
    cyc(1, 0, 0, 1, 0, v(10'h3FF, 0, 1, 0, 1, 0, 0), "sim_c0");
    cyc(1, 0, 0, 1, 0, v(10'h3FF, 0, 1, 0, 1, 1, 0), "sim_c1");
    cyc(1, 0, 1, 1, 0, idl, "sim_end");

    // video request arriving during a CPU slot
    cyc(1, 0, 0, 1, 0, idlw, "vc_req");
    cyc(1, 1, 0, 1, 0, v(10'h3FF, 0, 1, 0, 1, 0, 0), "vc_c0");
    cyc(1, 0, 0, 1, 0, v(10'h3FF, 0, 1, 0, 1, 1, 0), "vc_c1");
    cyc(1, 0, 0, 1, 0, v(10'h155, 0, 1, 0, 0, 1, 0), "vc_vf0");
    cyc(1, 0, 0, 1, 0, v(10'h155, 0, 1, 1, 0, 1, 0), "vc_vf1");
    cyc(1, 0, 1, 1, 0, idl, "vc_end");

    // overrun on the 4-cycle CPU instance
    cyc(0, 0, 1, 1, 1, idl, "ov_rst");
    cyc(1, 0, 1, 1, 1, idl, "ov_idle");
    cyc(1, 0, 0, 1, 1, idlw, "ov_req");
    cyc(1, 1, 0, 1, 1, v(10'h3FF, 0, 1, 0, 1, 0, 0), "ov_c0");
    cyc(1, 0, 0, 1, 1, v(10'h3FF, 0, 1, 0, 1, 0, 0), "ov_c1");
    cyc(1, 1, 0, 1, 1, v(10'h3FF, 0, 1, 0, 1, 0, 0), "ov_c2");
    cyc(1, 0, 0, 1, 1, v(10'h3FF, 0, 1, 0, 1, 1, 1), "ov_c3");
    cyc(1, 0, 0, 1, 1, v(10'h155, 0, 1, 0, 0, 1, 0), "ov_vf0");
    cyc(1, 0, 0, 1, 1, v(10'h155, 0, 1, 1, 0, 1, 0), "ov_vf1");
    cyc(1, 0, 1, 1, 1, idl, "ov_idle1");
    cyc(1, 0, 1, 1, 1, idl, "ov_idle2");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d left, required 0",
               exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
